nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that performs WIDTH-bit add/subtract by time-sharing one
//   Look_Ahead_Four_Bit_Adder instance over WIDTH/4 nibbles, LSB nibble first,
//   rippling carry through a register. Sits between a requester (start/done
//   handshake) and the 4-bit adder datapath; trades latency for area.
// PARAMETERS
//   WIDTH    16   operand/result width; multiple of 4, >= 4
//   NIBBLES  WIDTH/4 (localparam, derived) number of adder passes
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  operand A (latched on accepted start)
//   b      in   WIDTH  operand B (latched on accepted start)
//   cin    in   1      carry-in for add; ignored when sub=1
//   sub    in   1      1 = A - B (A + ~B + 1); latched with operands
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse: result valid
//   sum    out  WIDTH  result; held until next accepted start
//   cout   out  1      raw carry out of MSB nibble (sub: 1 = no borrow)
//   ovf    out  1      signed (two's-complement) overflow
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; idx=0, carry=0.
//   rst has priority over everything, aborts RUN/DONE at next edge, no partial
//   result retained.
// - States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge: latch A; latch B' = sub ? ~b : b; carry = sub ? 1 : cin;
//         idx=0; -> RUN. start=0: stay. sum/cout/ovf keep last values.
//   RUN:  each edge: adder inputs = A[idx], B'[idx], carry;
//         sum[4*idx+:4] <= adder out; carry <= adder cout; idx++.
//         When idx == NIBBLES-1 this edge: cout <= adder cout; ovf computed;
//         -> DONE.
//   DONE: done=1 for exactly this cycle; -> IDLE at next edge.
// - start is ignored in RUN and DONE (no queueing); it is accepted again from
//   the first IDLE cycle.
// - Latency: start sampled at edge E0; done high in the cycle after edge
//   E0+NIBBLES. Back-to-back throughput is one op per NIBBLES+2 cycles.
// - Operands changing after acceptance have no effect (latched copies used).
// - ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), evaluated on the final
//   sum; valid whenever done=1, held afterwards.
// - sum is updated nibble-by-nibble during RUN; consumers must sample only at
//   done. busy = (state == RUN); done = (state == DONE).
// - WIDTH=4: a single RUN cycle, done two cycles after the start edge.
// TESTING (WIDTH=16 unless stated)
//   1. a=0x1234, b=0x0FCD, cin=0, sub=0, start 1 cycle -> busy for 4 cycles;
//      done pulse 5 cycles after start edge; sum=0x2201, cout=0, ovf=0.
//   2. Full ripple: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0;
//      cin=1, a=b=0 -> sum=0x0001, cout=0.
//   3. Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE,
//      cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
//   4. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
//   5. start held high continuously plus operand changes during RUN ->
//      exactly one op per 6 cycles, each result from operands at accept edge.
//   6. rst asserted on 2nd RUN cycle -> next cycle busy=0, done=0, sum=0,
//      no done pulse; a following start (0x0001+0x0002) gives sum=0x0003.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle for the nibble-serial adder sequencer.
// master: requester side (drives start, a, b, cin, sub; sees busy, done, sum, cout, ovf).
// slave:  sequencer side (mirror of master).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: WIDTH-bit add/subtract by time-sharing one 4-bit look-ahead adder, LSB nibble first.
// Latency: start sampled at edge E0, done high in the cycle after edge E0+NIBBLES.
// Backpressure: none; start is only accepted in IDLE, ignored while busy or done.
// Ports: clk, rst (sync, active-high); bus (slave modport): start/a/b/cin/sub in,
//        busy/done/sum/cout/ovf out.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtract
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // ------------------------------------------------------------------
    // Shared 4-bit carry-look-ahead adder on the currently selected nibble
    // ------------------------------------------------------------------
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_g;
    logic [3:0] add_p;
    logic [4:0] add_c;
    logic [3:0] add_s;
    logic       add_co;

    assign add_a = a_q[{idx_q, 2'b00} +: 4];
    assign add_b = b_q[{idx_q, 2'b00} +: 4];
    assign add_g = add_a & add_b;
    assign add_p = add_a ^ add_b;

    // Carries expanded in sum-of-products form so no carry ripples through the nibble.
    assign add_c[0] = carry_q;
    assign add_c[1] = add_g[0] | (add_p[0] & add_c[0]);
    assign add_c[2] = add_g[1] | (add_p[1] & add_g[0]) | (add_p[1] & add_p[0] & add_c[0]);
    assign add_c[3] = add_g[2] | (add_p[2] & add_g[1]) | (add_p[2] & add_p[1] & add_g[0])
                    | (add_p[2] & add_p[1] & add_p[0] & add_c[0]);
    assign add_c[4] = add_g[3] | (add_p[3] & add_g[2]) | (add_p[3] & add_p[2] & add_g[1])
                    | (add_p[3] & add_p[2] & add_p[1] & add_g[0])
                    | (add_p[3] & add_p[2] & add_p[1] & add_p[0] & add_c[0]);

    assign add_s  = add_p ^ add_c[3:0];
    assign add_co = add_c[4];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract is A + ~B + 1: fold inversion and the +1 in at accept time.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= add_s;
                    carry_q                    <= add_co;
                    idx_q                      <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= add_co;
                        // add_s[3] is the final result MSB on the last pass.
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Prints one summary line with comparison and failure counts.
module tb_nibble_serial_adder_ctrl;
    localparam int W = 16;

    logic clk;
    logic rst;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Observations captured by run_op; comparisons happen in the test tasks.
    int          obs_lat;
    int          obs_busy;
    logic        obs_done_after;
    logic [W-1:0] obs_sum;
    logic        obs_cout;
    logic        obs_ovf;

    // Issue one op from IDLE, scramble operands after acceptance, wait for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tcin;
        bus.sub   = tsub;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_v;
        bus.cin   = ~tcin;
        bus.sub   = ~tsub;
        obs_lat   = -1;
        obs_busy  = 0;
        obs_sum   = 'x;
        obs_cout  = 1'bx;
        obs_ovf   = 1'bx;
        for (int c = 1; c <= 20 && obs_lat < 0; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) obs_busy++;
            if (bus.done === 1'b1) begin
                obs_lat  = c;
                obs_sum  = bus.sum;
                obs_cout = bus.cout;
                obs_ovf  = bus.ovf;
            end
        end
        @(negedge clk);
        obs_done_after = bus.done;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.cout, bus.ovf} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got busy=%b done=%b cout=%b ovf=%b want 0000",
                     bus.busy, bus.done, bus.cout, bus.ovf);
        end
        total++;
        if (bus.sum !== 16'h0000) begin
            bad++;
            $display("FAIL reset_sum got %h want 0000", bus.sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        total++;
        if (obs_lat !== 5) begin
            bad++;
            $display("FAIL basic_latency got %0d want 5", obs_lat);
        end
        total++;
        if (obs_busy !== 4) begin
            bad++;
            $display("FAIL basic_busy_cycles got %0d want 4", obs_busy);
        end
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'h2201, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_result got sum=%h cout=%b ovf=%b want 2201/0/0",
                     obs_sum, obs_cout, obs_ovf);
        end
        total++;
        if (obs_done_after !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_width got done=%b want 0 one cycle later", obs_done_after);
        end
        // Result must hold in IDLE while inputs wander and start stays low.
        repeat (3) @(negedge clk);
        total++;
        if (bus.sum !== 16'h2201) begin
            bad++;
            $display("FAIL basic_hold got %h want 2201", bus.sum);
        end
    endtask

    task automatic test_ripple();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ripple_full got sum=%h cout=%b ovf=%b want 0000/1/0",
                     obs_sum, obs_cout, obs_ovf);
        end
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        total++;
        if ({obs_sum, obs_cout} !== {16'h0001, 1'b0}) begin
            bad++;
            $display("FAIL ripple_cin got sum=%h cout=%b want 0001/0", obs_sum, obs_cout);
        end
        run_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'h0100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ripple_cin_carry got sum=%h cout=%b ovf=%b want 0100/0/0",
                     obs_sum, obs_cout, obs_ovf);
        end
    endtask

    task automatic test_subtract();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub_borrow got sum=%h cout=%b ovf=%b want FFFE/0/0",
                     obs_sum, obs_cout, obs_ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sub_ovf got sum=%h cout=%b ovf=%b want 7FFF/1/1",
                     obs_sum, obs_cout, obs_ovf);
        end
    endtask

    task automatic test_overflow();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        total++;
        if ({obs_sum, obs_cout, obs_ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf got sum=%h cout=%b ovf=%b want 8000/0/1",
                     obs_sum, obs_cout, obs_ovf);
        end
    endtask

    // start held high; operands change every cycle, only those present at
    // accept edges E0, E6, E12 may show up in results.
    task automatic test_back_to_back();
        logic [W-1:0] exp_sum [3];
        int           ndone;
        exp_sum[0] = 16'h0033;  // 0x0011 + 0x0022
        exp_sum[1] = 16'h3000;  // 0x1000 + 0x2000
        exp_sum[2] = 16'hFF00;  // 0x0100 - 0x0200
        ndone = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = 16'h0011; bus.b = 16'h0022; bus.cin = 1'b0; bus.sub = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            if (k + 1 == 6) begin
                bus.a = 16'h1000; bus.b = 16'h2000; bus.cin = 1'b0; bus.sub = 1'b0;
            end else if (k + 1 == 12) begin
                bus.a = 16'h0100; bus.b = 16'h0200; bus.cin = 1'b0; bus.sub = 1'b1;
            end else begin
                bus.a   = 16'(k * 16'h1357);
                bus.b   = 16'(k * 16'h0F0F);
                bus.sub = k[0];
                bus.cin = ~k[0];
            end
            @(negedge clk);
            total++;
            if (bus.busy !== ((k % 6) < 4)) begin
                bad++;
                $display("FAIL b2b_busy cycle %0d got %b want %b", k, bus.busy, ((k % 6) < 4));
            end
            total++;
            if (bus.done !== ((k % 6) == 4)) begin
                bad++;
                $display("FAIL b2b_done cycle %0d got %b want %b", k, bus.done, ((k % 6) == 4));
            end
            if (bus.done === 1'b1 && ndone < 3) begin
                total++;
                if (bus.sum !== exp_sum[ndone]) begin
                    bad++;
                    $display("FAIL b2b_sum op %0d got %h want %h", ndone, bus.sum, exp_sum[ndone]);
                end
                ndone++;
            end
        end
        bus.start = 1'b0;
        total++;
        if (ndone !== 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", ndone);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int ndone;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
        @(posedge clk); #1;   // E0: accepted
        bus.start = 1'b0;
        @(posedge clk); #1;   // E1: second RUN cycle begins
        rst = 1'b1;
        @(posedge clk); #1;   // E2: reset taken
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL abort_flags got busy=%b done=%b want 00", bus.busy, bus.done);
        end
        total++;
        if (bus.sum !== 16'h0000) begin
            bad++;
            $display("FAIL abort_sum got %h want 0000", bus.sum);
        end
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL abort_no_done got %0d pulses want 0", ndone);
        end
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
        total++;
        if (obs_lat !== 5 || obs_sum !== 16'h0003) begin
            bad++;
            $display("FAIL abort_recover got lat=%0d sum=%h want 5/0003", obs_lat, obs_sum);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_add();
        test_ripple();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
